// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the memory arbiter slice: the arbiter FSM state
// encoding and the default fairness / watchdog parameters.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int DEFAULT_FAIR_LIMIT = 4;
    localparam int DEFAULT_TIMEOUT    = 255;

endpackage

// File: rtl/mem_arb_wdog.sv
// mem_arb_wdog
// Busy-cycle watchdog for the memory arbiter. Counts cycles spent waiting
// for m_ack and flags the last allowed busy cycle.
//   clk     : clock, rising edge
//   rst     : asynchronous reset, active low
//   clear   : restart the count (a new grant is being made)
//   busy    : arbiter is waiting on memory this cycle
//   expired : this is busy cycle number TIMEOUT with no ack yet
module mem_arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic busy,
    output logic expired
);

    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] busy_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cnt <= '0;
        end else if (clear) begin
            busy_cnt <= '0;
        end else if (busy) begin
            busy_cnt <= busy_cnt + CW'(1);
        end
    end

    // The counter is zero in the first busy cycle, so LAST marks busy cycle TIMEOUT.
    assign expired = busy && (busy_cnt == LAST);

endmodule

// File: rtl/mem_arb.sv
// mem_arb
// Two-master (instruction fetch / data) arbiter in front of a single
// memory port. One transaction at a time: grant, wait for m_ack (or a
// watchdog abort), then a one-cycle response pulse to the owner.
//   clk, rst                      : clock and asynchronous active-low reset
//   if_req/if_addr                : fetch request, held until if_gnt
//   if_gnt, if_rvalid             : fetch accept / completion pulses
//   d_req/d_we/d_be/d_addr/d_wdata: data request, held until d_gnt
//   d_gnt, d_rvalid               : data accept / completion pulses
//   rdata, err                    : registered response, err = timeout abort
//   m_req/m_we/m_be/m_addr/m_wdata: memory request with latched payload
//   m_ack, m_rdata                : memory handshake and read data
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int FAIR_LIMIT = DEFAULT_FAIR_LIMIT,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    localparam logic [2:0] FAIR_MAX = 3'(FAIR_LIMIT);

    state_t      state, state_nxt;
    logic [2:0]  fair_cnt, fair_cnt_nxt;
    logic        if_gnt_nxt, d_gnt_nxt, if_rvalid_nxt, d_rvalid_nxt;
    logic        m_req_nxt, m_we_nxt, err_nxt;
    logic [3:0]  m_be_nxt;
    logic [31:0] m_addr_nxt, m_wdata_nxt, rdata_nxt;
    logic        grant;
    logic        busy;
    logic        expired;

    assign busy = (state == BUSY_I) || (state == BUSY_D);

    mem_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (grant),
        .busy    (busy),
        .expired (expired)
    );

    // Next-state and next-output logic. Every output is registered, so the
    // grant pulse and m_req appear together right after the grant edge, and
    // the rvalid pulse coincides exactly with the RESP cycle.
    always_comb begin
        state_nxt     = state;
        fair_cnt_nxt  = fair_cnt;
        grant         = 1'b0;
        if_gnt_nxt    = 1'b0;
        d_gnt_nxt     = 1'b0;
        if_rvalid_nxt = 1'b0;
        d_rvalid_nxt  = 1'b0;
        m_req_nxt     = m_req;
        m_we_nxt      = m_we;
        m_be_nxt      = m_be;
        m_addr_nxt    = m_addr;
        m_wdata_nxt   = m_wdata;
        rdata_nxt     = rdata;
        err_nxt       = err;

        case (state)
            IDLE: begin
                // Data has priority unless fetch has been starved FAIR_LIMIT times.
                if (d_req && !(if_req && (fair_cnt == FAIR_MAX))) begin
                    grant       = 1'b1;
                    state_nxt   = BUSY_D;
                    d_gnt_nxt   = 1'b1;
                    m_req_nxt   = 1'b1;
                    m_we_nxt    = d_we;
                    m_be_nxt    = d_be;
                    m_addr_nxt  = d_addr;
                    m_wdata_nxt = d_wdata;
                    if (if_req && (fair_cnt < FAIR_MAX)) begin
                        fair_cnt_nxt = fair_cnt + 3'd1;
                    end
                end else if (if_req) begin
                    grant        = 1'b1;
                    state_nxt    = BUSY_I;
                    if_gnt_nxt   = 1'b1;
                    m_req_nxt    = 1'b1;
                    m_we_nxt     = 1'b0;
                    m_be_nxt     = 4'hF;
                    m_addr_nxt   = if_addr;
                    m_wdata_nxt  = 32'h0;
                    fair_cnt_nxt = 3'd0;
                end
            end
            BUSY_I, BUSY_D: begin
                // An ack in the watchdog's last cycle still completes normally.
                if (m_ack) begin
                    state_nxt     = RESP;
                    m_req_nxt     = 1'b0;
                    rdata_nxt     = m_we ? 32'h0 : m_rdata;
                    err_nxt       = 1'b0;
                    if_rvalid_nxt = (state == BUSY_I);
                    d_rvalid_nxt  = (state == BUSY_D);
                end else if (expired) begin
                    state_nxt     = RESP;
                    m_req_nxt     = 1'b0;
                    rdata_nxt     = 32'h0;
                    err_nxt       = 1'b1;
                    if_rvalid_nxt = (state == BUSY_I);
                    d_rvalid_nxt  = (state == BUSY_D);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fair_cnt  <= 3'd0;
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_be      <= 4'h0;
            m_addr    <= 32'h0;
            m_wdata   <= 32'h0;
            rdata     <= 32'h0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            fair_cnt  <= fair_cnt_nxt;
            if_gnt    <= if_gnt_nxt;
            d_gnt     <= d_gnt_nxt;
            if_rvalid <= if_rvalid_nxt;
            d_rvalid  <= d_rvalid_nxt;
            m_req     <= m_req_nxt;
            m_we      <= m_we_nxt;
            m_be      <= m_be_nxt;
            m_addr    <= m_addr_nxt;
            m_wdata   <= m_wdata_nxt;
            rdata     <= rdata_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter FAIR_LIMIT, default 4: the maximum number of consecutive data grants while if_req is pending.
REQ-002 SHALL have parameter TIMEOUT, default 255: the number of busy cycles without m_ack before the transaction is aborted.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 if_req  in  1  fetch request; held with if_addr until if_gnt.
REQ-006 if_addr  in  32  fetch word address.
REQ-007 if_gnt  out  1  one-cycle pulse: fetch request accepted.
REQ-008 if_rvalid  out  1  one-cycle pulse: fetch complete; rdata/err valid.
REQ-009 d_req  in  1  data request; held with payload until d_gnt.
REQ-010 d_we  in  1  1 = store, 0 = load.
REQ-011 d_be  in  4  store byte enables.
REQ-012 d_addr  in  32  data address.
REQ-013 d_wdata  in  32  store data.
REQ-014 d_gnt  out  1  one-cycle pulse: data request accepted.
REQ-015 d_rvalid  out  1  one-cycle pulse: load data valid or store complete.
REQ-016 rdata  out  32  registered read data, shared by both requesters.
REQ-017 err  out  1  qualifies the rvalid pulse; 1 = timeout abort.
REQ-018 m_req  out  1  memory request; held high until m_ack or abort.
REQ-019 m_we / m_be / m_addr / m_wdata  out  1/4/32/32  latched payload, stable while m_req is high.
REQ-020 m_ack  in  1  memory accepted or completed the access; m_rdata valid in the same cycle.
REQ-021 m_rdata  in  32  memory read data.

Function
REQ-022 SHALL have states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE with a request pending: grant, latch payload, pulse gnt, raise m_req, and go to BUSY_I or BUSY_D at the same edge.
- Grant-to-m_req latency: 0 cycles after the grant edge.
REQ-023 Arbitration when both requests are high: data wins, unless fair_cnt == FAIR_LIMIT, in which case fetch wins.
REQ-024 fair_cnt (3 bits) SHALL:
- increment on each data grant made while if_req is high;
- clear on every fetch grant;
- saturate at FAIR_LIMIT.
REQ-025 A fetch grant SHALL drive m_we=0, m_be=4'hF, m_wdata=0.
REQ-026 In BUSY_* with m_ack high: drop m_req, register rdata <= m_rdata (0 for stores), set err=0, and go to RESP.
REQ-027 RESP SHALL pulse the owner's rvalid for exactly one cycle, then go to IDLE; no grants occur in RESP.
REQ-028 A busy-cycle counter SHALL clear on each grant and increment each BUSY_* cycle. When it reaches TIMEOUT-1 without m_ack:
- drop m_req;
- set rdata=0, err=1;
- go to RESP.
REQ-029 m_ack arriving in the same cycle as the timeout SHALL win: normal completion, err=0.
REQ-030 m_ack seen in IDLE or RESP SHALL be ignored.
REQ-031 Requests arriving while busy SHALL wait; a requester's gnt never pulses while its rvalid is outstanding.
REQ-032 Minimum occupancy is 3 cycles per transaction (grant, ack, RESP).

Reset
REQ-033 While rst=0, SHALL force state=IDLE, all outputs 0, and fair_cnt and the busy counter to 0, regardless of any in-flight transaction.
REQ-034 An in-flight transaction interrupted by reset SHALL be dropped; no rvalid is produced for it after reset release.

Structure
REQ-035 Package mem_arb_pkg SHALL hold the state enum and the default values of FAIR_LIMIT and TIMEOUT.
REQ-036 Sub-module mem_arb_wdog SHALL contain the busy counter and timeout compare; all other logic stays in mem_arb.

Verification
REQ-037 Fetch only: if_req, if_addr=0x100; m_ack 2 cycles after grant, m_rdata=0xDEADBEEF -> if_rvalid one cycle after ack, rdata=0xDEADBEEF, err=0.
REQ-038 Both requests held continuously, FAIR_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-039 Store d_addr=0x20, d_be=4'b0011, d_wdata=0x1234 -> m_we=1, m_be=4'b0011, m_wdata=0x1234 stable until ack; d_rvalid with rdata=0.
REQ-040 m_ack never asserted, TIMEOUT=8 -> m_req falls after 8 busy cycles; rvalid with err=1, rdata=0; the next request is served normally.
REQ-041 rst asserted mid-BUSY_D -> all outputs 0 immediately; after release, no d_rvalid appears and a fresh fetch completes normally.
